// File: rtl/dram_ctrl.sv
// dram_ctrl: multiplexed-address sequencer for a 64K x 8 DRAM.
// Splits flat requests into row/column strobes and inserts RAS-only refresh.
module dram_ctrl #(
  parameter int RAS_TO_CAS     = 2,
  parameter int CAS_WIDTH      = 2,
  parameter int PRECHARGE      = 2,
  parameter int REFRESH_PERIOD = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        req,
  input  logic        req_rw,
  input  logic [15:0] req_addr,
  input  logic [7:0]  req_wdata,
  output logic        ack,
  output logic        done,
  output logic [7:0]  rdata,
  output logic        busy,
  output logic [7:0]  dram_addr,
  output logic        dram_ras,
  output logic        dram_cas,
  output logic        dram_rw,
  output logic [7:0]  dram_dout,
  input  logic [7:0]  dram_din
);

  typedef enum logic [2:0] {
    IDLE,
    ROW,
    RCD,
    COL,
    CAS,
    RFSH,
    PRE
  } state_t;

  localparam int RW = $clog2(REFRESH_PERIOD + 1);

  localparam logic [RW-1:0] RMAX = RW'(REFRESH_PERIOD - 1);
  localparam logic [7:0] RCD_LAST  = 8'(RAS_TO_CAS - 1);
  localparam logic [7:0] CAS_LAST  = 8'(CAS_WIDTH - 1);
  localparam logic [7:0] RFSH_LAST = 8'(RAS_TO_CAS + CAS_WIDTH - 1);
  localparam logic [7:0] PRE_LAST  = 8'(PRECHARGE - 1);

  state_t        state;
  logic [7:0]    cnt;
  logic [RW-1:0] rcnt;
  logic [7:0]    rrow;
  logic          pending;
  logic          is_rfsh;
  logic [7:0]    col;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      rcnt      <= '0;
      rrow      <= '0;
      pending   <= 1'b0;
      is_rfsh   <= 1'b0;
      col       <= '0;
      ack       <= 1'b0;
      done      <= 1'b0;
      rdata     <= '0;
      busy      <= 1'b0;
      dram_addr <= '0;
      dram_ras  <= 1'b1;
      dram_cas  <= 1'b1;
      dram_rw   <= 1'b1;
      dram_dout <= '0;
    end else begin
      ack  <= 1'b0;
      done <= 1'b0;
      cnt  <= cnt + 8'd1;

      // wraps while a refresh is pending are simply absorbed
      if (rcnt == RMAX) begin
        rcnt    <= '0;
        pending <= 1'b1;
      end else begin
        rcnt <= rcnt + 1'b1;
      end

      unique case (state)
        IDLE: begin
          cnt <= '0;
          if (pending) begin
            state     <= ROW;
            is_rfsh   <= 1'b1;
            busy      <= 1'b1;
            dram_addr <= rrow;
          end else if (req) begin
            state     <= ROW;
            is_rfsh   <= 1'b0;
            busy      <= 1'b1;
            ack       <= 1'b1;
            dram_addr <= req_addr[7:0];
            col       <= req_addr[15:8];
            dram_rw   <= req_rw;
            dram_dout <= req_wdata;
          end
        end
        ROW: begin
          dram_ras <= 1'b0;
          cnt      <= '0;
          state    <= is_rfsh ? RFSH : RCD;
        end
        RCD: begin
          if (cnt == RCD_LAST) begin
            dram_addr <= col;
            cnt       <= '0;
            state     <= COL;
          end
        end
        COL: begin
          dram_cas <= 1'b0;
          cnt      <= '0;
          state    <= CAS;
        end
        CAS: begin
          if (cnt == CAS_LAST) begin
            if (dram_rw) begin
              rdata <= dram_din;
            end
            dram_cas <= 1'b1;
            dram_ras <= 1'b1;
            dram_rw  <= 1'b1;
            done     <= 1'b1;
            cnt      <= '0;
            state    <= PRE;
          end
        end
        RFSH: begin
          if (cnt == RFSH_LAST) begin
            dram_ras <= 1'b1;
            rrow     <= rrow + 8'd1;
            pending  <= 1'b0;
            cnt      <= '0;
            state    <= PRE;
          end
        end
        PRE: begin
          if (cnt == PRE_LAST) begin
            busy  <= 1'b0;
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
